// File: rtl/keccak_padder_param.sv
// Keccak input padder: packs IN_BYTES-wide message words into RATE_BITS-wide
// rate blocks. Applies multi-rate padding (SUFFIX ... 0x80) and hands each
// block to the permutation core with an out_ready/f_ack handshake.
module keccak_padder_param #(
  parameter int          IN_BYTES  = 4,
  parameter int          RATE_BITS = 576,
  parameter logic [7:0]  SUFFIX    = 8'h01
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [8*IN_BYTES-1:0]         in,
  input  logic                          in_ready,
  input  logic                          is_last,
  input  logic [$clog2(IN_BYTES)-1:0]   byte_num,
  input  logic                          f_ack,
  output logic                          buffer_full,
  output logic [RATE_BITS-1:0]          out,
  output logic                          out_ready,
  output logic                          out_last
);
  localparam int W     = 8 * IN_BYTES;
  localparam int WORDS = RATE_BITS / W;
  localparam int CW    = $clog2(WORDS + 1);

  typedef enum logic [1:0] {ABSORB, PAD_FILL, FULL, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [RATE_BITS-1:0] out_q, out_d;
  logic                 last_q, last_d;
  logic                 full_q, full_d;
  logic                 rdy_q, rdy_d;

  logic                 final_wd;   // the word being written lands at WORDS-1
  logic [W-1:0]         last_word;  // padded version of the final message word
  logic [W-1:0]         pad_word;   // filler word shifted in during PAD_FILL

  assign final_wd = (cnt_q == CW'(WORDS - 1));

  // Build the padded last word: kept bytes, SUFFIX, zeros, 0x80 if block end
  always_comb begin
    last_word = '0;
    for (int b = 0; b < IN_BYTES; b++) begin
      if (b < int'(byte_num))
        last_word[W-1-8*b -: 8] = in[W-1-8*b -: 8];
      else if (b == int'(byte_num))
        last_word[W-1-8*b -: 8] = SUFFIX;
    end
    if (final_wd) last_word[7:0] = last_word[7:0] | 8'h80;
    pad_word = final_wd ? W'(8'h80) : '0;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ABSORB;
      cnt_q   <= '0;
      out_q   <= '0;
      last_q  <= 1'b0;
      full_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      last_q  <= last_d;
      full_q  <= full_d;
      rdy_q   <= rdy_d;
    end
  end

  // Next-state: absorb words, fill padding, hold the block until acknowledged
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    last_d  = last_q;
    unique case (state_q)
      ABSORB: begin
        if (in_ready && !full_q) begin
          cnt_d = cnt_q + CW'(1);
          if (is_last) begin
            out_d   = (out_q << W) | RATE_BITS'(last_word);
            state_d = final_wd ? FULL : PAD_FILL;
            last_d  = 1'b1;
          end else begin
            out_d = (out_q << W) | RATE_BITS'(in);
            if (final_wd) begin
              state_d = FULL;
              last_d  = 1'b0;
            end
          end
        end
      end
      PAD_FILL: begin
        out_d = (out_q << W) | RATE_BITS'(pad_word);
        cnt_d = cnt_q + CW'(1);
        if (final_wd) state_d = FULL;
      end
      FULL: begin
        // Clearing the block on release keeps stale message data off the bus
        if (f_ack) begin
          cnt_d   = '0;
          out_d   = '0;
          state_d = last_q ? DONE : ABSORB;
        end
      end
      DONE: ;
      default: state_d = ABSORB;
    endcase
  end

  // Outputs are registered from the next state so they rise the cycle after
  always_comb begin
    full_d = (state_d == FULL) || (state_d == DONE);
    rdy_d  = (state_d == FULL);
  end

  assign out         = out_q;
  assign out_ready   = rdy_q;
  assign out_last    = last_q;
  assign buffer_full = full_q;
endmodule

// File: tb/tb_keccak_padder_param.sv
// Directed bench for keccak_padder_param: default 32-bit/576-bit instance
// plus a 64-bit/1088-bit SHA-3 instance sharing clock and reset.
module tb_keccak_padder_param;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // instance A: IN_BYTES=4, RATE_BITS=576, SUFFIX=0x01
  logic [31:0]  in_a = '0;
  logic         inr_a = 1'b0, last_a = 1'b0, ack_a = 1'b0;
  logic [1:0]   bn_a = '0;
  logic         full_a, rdy_a, olast_a;
  logic [575:0] out_a;

  // instance B: IN_BYTES=8, RATE_BITS=1088, SUFFIX=0x06
  logic [63:0]   in_b = '0;
  logic          inr_b = 1'b0, last_b = 1'b0, ack_b = 1'b0;
  logic [2:0]    bn_b = '0;
  logic          full_b, rdy_b, olast_b;
  logic [1087:0] out_b;

  keccak_padder_param #(.IN_BYTES(4), .RATE_BITS(576), .SUFFIX(8'h01)) dut_a (
    .clk(clk), .reset(reset), .in(in_a), .in_ready(inr_a), .is_last(last_a),
    .byte_num(bn_a), .f_ack(ack_a), .buffer_full(full_a), .out(out_a),
    .out_ready(rdy_a), .out_last(olast_a));

  keccak_padder_param #(.IN_BYTES(8), .RATE_BITS(1088), .SUFFIX(8'h06)) dut_b (
    .clk(clk), .reset(reset), .in(in_b), .in_ready(inr_b), .is_last(last_b),
    .byte_num(bn_b), .f_ack(ack_b), .buffer_full(full_b), .out(out_b),
    .out_ready(rdy_b), .out_last(olast_b));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] wa(input int i);
    return out_a[575-32*i -: 32];
  endfunction

  function automatic logic [63:0] wb(input int i);
    return out_b[1087-64*i -: 64];
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_a(input logic [31:0] d, input logic lst, input logic [1:0] bn);
    in_a = d; inr_a = 1'b1; last_a = lst; bn_a = bn;
    step();
    inr_a = 1'b0; last_a = 1'b0; bn_a = '0;
  endtask

  task automatic pulse_ack_a();
    ack_a = 1'b1; step(); ack_a = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; #2;
    reset = 1'b1;
    step();
  endtask

  // cycles counted from the cycle the first word was presented
  task automatic wait_rdy(input bit sel_b, input int start, output int cyc);
    cyc = start;
    while (!(sel_b ? rdy_b : rdy_a) && cyc < 200) begin
      step(); cyc++;
    end
    if (cyc >= 200) chk("rdy_timeout", 64'(cyc), 64'(0));
  endtask

  logic [31:0] saved [18];
  int cyc;

  initial begin
    // reset state
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 64'(rdy_a), 64'(0));
    chk("rst_full", 64'(full_a), 64'(0));
    chk("rst_last", 64'(olast_a), 64'(0));
    chk("rst_out", 64'(|out_a), 64'(0));
    reset = 1'b1;
    step();

    // "Hello, world!" with 1 valid byte in the last word, padded by PAD_FILL
    send_a(32'h48656c6c, 1'b0, 2'd0);
    chk("t1_notfull", 64'(full_a), 64'(0));
    send_a(32'h6f2c2077, 1'b0, 2'd0);
    send_a(32'h6f726c64, 1'b0, 2'd0);
    send_a(32'h21202020, 1'b1, 2'd1);
    chk("t1_rdy_early", 64'(rdy_a), 64'(0));
    wait_rdy(1'b0, 4, cyc);
    chk("t1_latency", 64'(cyc), 64'(18));
    chk("t1_w0", 64'(wa(0)), 64'h48656c6c);
    chk("t1_w2", 64'(wa(2)), 64'h6f726c64);
    chk("t1_w3", 64'(wa(3)), 64'h21010000);
    for (int i = 4; i <= 16; i++) chk($sformatf("t1_w%0d", i), 64'(wa(i)), 64'(0));
    chk("t1_w17", 64'(wa(17)), 64'h00000080);
    chk("t1_last", 64'(olast_a), 64'(1));
    chk("t1_full", 64'(full_a), 64'(1));
    // release the final block -> DONE
    pulse_ack_a();
    chk("done_rdy", 64'(rdy_a), 64'(0));
    chk("done_full", 64'(full_a), 64'(1));
    chk("done_out", 64'(|out_a), 64'(0));
    // f_ack and input in DONE are ignored
    pulse_ack_a();
    send_a(32'hcafef00d, 1'b1, 2'd2);
    repeat (3) step();
    chk("done_ack_rdy", 64'(rdy_a), 64'(0));
    chk("done_ack_full", 64'(full_a), 64'(1));
    chk("done_ack_out", 64'(|out_a), 64'(0));

    // 18 full words, block held against input, then a suffix-only block
    do_reset();
    for (int i = 0; i < 18; i++) send_a(32'h10000000 + 32'(i), 1'b0, 2'd0);
    chk("t2_rdy", 64'(rdy_a), 64'(1));
    chk("t2_last", 64'(olast_a), 64'(0));
    chk("t2_w0", 64'(wa(0)), 64'h10000000);
    chk("t2_w17", 64'(wa(17)), 64'h10000011);
    for (int i = 0; i < 18; i++) saved[i] = wa(i);
    send_a(32'hdeadbeef, 1'b0, 2'd0);
    send_a(32'h01234567, 1'b1, 2'd3);
    for (int i = 0; i < 18; i++) chk($sformatf("t2_hold%0d", i), 64'(wa(i)), 64'(saved[i]));
    chk("t2_hold_rdy", 64'(rdy_a), 64'(1));
    pulse_ack_a();
    chk("t2_ack_rdy", 64'(rdy_a), 64'(0));
    chk("t2_ack_full", 64'(full_a), 64'(0));
    send_a(32'h00000000, 1'b1, 2'd0);
    wait_rdy(1'b0, 1, cyc);
    chk("t2_latency", 64'(cyc), 64'(18));
    chk("t2b_w0", 64'(wa(0)), 64'h01000000);
    chk("t2b_w1", 64'(wa(1)), 64'h00000000);
    chk("t2b_w17", 64'(wa(17)), 64'h00000080);
    chk("t2b_last", 64'(olast_a), 64'(1));

    // last word lands at WORDS-1: 0x81 merge, no PAD_FILL
    do_reset();
    for (int i = 0; i < 17; i++) send_a(32'h20000000 + 32'(i), 1'b0, 2'd0);
    chk("t3_rdy_pre", 64'(rdy_a), 64'(0));
    send_a(32'h61626320, 1'b1, 2'd3);
    chk("t3_rdy", 64'(rdy_a), 64'(1));
    chk("t3_w0", 64'(wa(0)), 64'h20000000);
    chk("t3_w16", 64'(wa(16)), 64'h20000010);
    chk("t3_w17", 64'(wa(17)), 64'h61626381);
    chk("t3_last", 64'(olast_a), 64'(1));

    // SHA-3 instance, single suffix-only word
    do_reset();
    in_b = '0; bn_b = '0; last_b = 1'b1; inr_b = 1'b1;
    step();
    inr_b = 1'b0; last_b = 1'b0;
    wait_rdy(1'b1, 1, cyc);
    chk("t4_latency", 64'(cyc), 64'(17));
    chk("t4_w0", wb(0), 64'h0600000000000000);
    chk("t4_w8", wb(8), 64'h0000000000000000);
    chk("t4_w16", wb(16), 64'h0000000000000080);
    chk("t4_last", 64'(olast_b), 64'(1));
    chk("t4_full", 64'(full_b), 64'(1));

    // asynchronous reset mid-absorb, then a clean message
    do_reset();
    for (int i = 0; i < 5; i++) send_a(32'h30000000 + 32'(i), 1'b0, 2'd0);
    chk("t5_pre_out", 64'(wa(17)), 64'h30000004);
    #2 reset = 1'b0;
    #1;
    chk("t5_out", 64'(|out_a), 64'(0));
    chk("t5_rdy", 64'(rdy_a), 64'(0));
    chk("t5_full", 64'(full_a), 64'(0));
    chk("t5_last", 64'(olast_a), 64'(0));
    chk("t5_b_rdy", 64'(rdy_b), 64'(0));
    reset = 1'b1;
    step();
    send_a(32'h41424344, 1'b1, 2'd2);
    wait_rdy(1'b0, 1, cyc);
    chk("t5_latency", 64'(cyc), 64'(18));
    chk("t5_w0", 64'(wa(0)), 64'h41420100);
    chk("t5_w1", 64'(wa(1)), 64'h00000000);
    chk("t5_w17", 64'(wa(17)), 64'h00000080);
    chk("t5_lastflag", 64'(olast_a), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
